// File: rtl/controlador_interrupcao.sv
// Interrupt controller: round-robin quantum timer plus HALT trap, latching cause and resume PC
// until the OS acknowledges. Optional interrupt counter enabled by CONTADOR_INTERRUPCOES_EN.
module controlador_interrupcao #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic                  set_clock,
  input  logic [TIME_WIDTH-1:0] int_time,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  get_interruption,
  output logic                  int_clk,
  output logic                  int_halt,
  output logic [DATA_WIDTH-1:0] qual_interrupcao,
  output logic [ADDR_WIDTH-1:0] pc_interrup,
  output logic                  pendente,
  output logic [15:0]           total_interrupcoes
);

  typedef enum logic [1:0] {OCIOSO, CONTANDO, PENDENTE} estado_t;

  estado_t               estado_q, estado_d;
  logic [TIME_WIDTH-1:0] contador_q, contador_d;
  logic                  int_clk_q, int_clk_d;
  logic                  int_halt_q, int_halt_d;
  logic [1:0]            causa_q, causa_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    int_clk_d  = 1'b0;
    int_halt_d = 1'b0;
    causa_d    = causa_q;
    pc_d       = pc_q;
    // HALT outranks both a reload and a coinciding expiry
    if (estado_q != PENDENTE && halt) begin
      int_halt_d = 1'b1;
      causa_d    = 2'd2;
      pc_d       = pc;
      contador_d = '0;
      estado_d   = PENDENTE;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (set_clock && int_time != '0) begin
            contador_d = int_time;
            estado_d   = CONTANDO;
          end
        end
        CONTANDO: begin
          if (set_clock) begin
            contador_d = int_time;
            if (int_time == '0) estado_d = OCIOSO;
          end else if (contador_q == TIME_WIDTH'(1)) begin
            int_clk_d  = 1'b1;
            causa_d    = 2'd1;
            pc_d       = pc_next;
            contador_d = '0;
            estado_d   = PENDENTE;
          end else begin
            contador_d = contador_q - TIME_WIDTH'(1);
          end
        end
        PENDENTE: begin
          if (get_interruption) begin
            causa_d  = 2'd0;
            estado_d = OCIOSO;
          end
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      int_clk_q  <= 1'b0;
      int_halt_q <= 1'b0;
      causa_q    <= 2'd0;
      pc_q       <= '0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      int_clk_q  <= int_clk_d;
      int_halt_q <= int_halt_d;
      causa_q    <= causa_d;
      pc_q       <= pc_d;
    end
  end

  assign int_clk          = int_clk_q;
  assign int_halt         = int_halt_q;
  assign qual_interrupcao = {{(DATA_WIDTH-2){1'b0}}, causa_q};
  assign pc_interrup      = pc_q;
  assign pendente         = (estado_q == PENDENTE);

`ifdef CONTADOR_INTERRUPCOES_EN
  logic [15:0] total_q;

  // Counts on the edge that launches the pulse; saturates instead of wrapping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                    total_q <= '0;
    else if ((int_clk_d || int_halt_d) && total_q != 16'hFFFF) total_q <= total_q + 16'd1;
  end

  assign total_interrupcoes = total_q;
`else
  assign total_interrupcoes = '0;
`endif

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_controlador_interrupcao;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic        set_clock = 1'b0;
  logic [15:0] int_time = '0;
  logic [12:0] pc = '0;
  logic [12:0] pc_next = '0;
  logic        get_interruption = 1'b0;
  logic        int_clk, int_halt, pendente;
  logic [31:0] qual_interrupcao;
  logic [12:0] pc_interrup;
  logic [15:0] total_interrupcoes;

  controlador_interrupcao dut (
    .clock(clock), .reset_n(reset_n), .halt(halt), .set_clock(set_clock),
    .int_time(int_time), .pc(pc), .pc_next(pc_next),
    .get_interruption(get_interruption), .int_clk(int_clk), .int_halt(int_halt),
    .qual_interrupcao(qual_interrupcao), .pc_interrup(pc_interrup),
    .pendente(pendente), .total_interrupcoes(total_interrupcoes)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clk;
    logic        hlt;
    logic [31:0] causa;
    logic [12:0] pcx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   npulse = 0;
  int   nexp = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && (int_clk || int_halt)) begin
      npulse++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, int_halt, int_clk}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("int_clk", {31'd0, int_clk}, {31'd0, e.clk});
        chk("int_halt", {31'd0, int_halt}, {31'd0, e.hlt});
        chk("qual", qual_interrupcao, e.causa);
        chk("pc_interrup", {19'd0, pc_interrup}, {19'd0, e.pcx});
        chk("pendente_at_pulse", {31'd0, pendente}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pulse(input logic c, input logic h, input logic [31:0] causa,
                              input logic [12:0] p, input int at);
    exp_t e;
    e.clk = c; e.hlt = h; e.causa = causa; e.pcx = p; e.cyc = at;
    sb.push_back(e);
    nexp++;
  endtask

  task automatic wait_pulse(input int maxc);
    int n0;
    n0 = npulse;
    for (int i = 0; i < maxc; i++) begin
      if (npulse != n0) return;
      tick();
    end
    chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [15:0] t, output int lcyc);
    set_clock = 1'b1; int_time = t;
    tick();
    lcyc = cyc;
    set_clock = 1'b0;
  endtask

  task automatic ack();
    get_interruption = 1'b1;
    tick();
    get_interruption = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, n0;
    // reset state
    tick(); tick();
    chk("rst_int_clk", {31'd0, int_clk}, 32'd0);
    chk("rst_qual", qual_interrupcao, 32'd0);
    chk("rst_pc_interrup", {19'd0, pc_interrup}, 32'd0);
    chk("rst_pendente", {31'd0, pendente}, 32'd0);
    chk("rst_total", {16'd0, total_interrupcoes}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: quantum 5, resume at pc_next
    pc = 13'h011; pc_next = 13'h040;
    load(16'd5, l);
    expect_pulse(1'b1, 1'b0, 32'd1, 13'h040, l + 5);
    wait_pulse(12);
    chk("t1_one_cycle", {31'd0, int_clk}, 32'd0);
    chk("t1_pendente", {31'd0, pendente}, 32'd1);
    chk("t1_qual", qual_interrupcao, 32'd1);
    chk("t1_pc", {19'd0, pc_interrup}, 32'h040);

    // 2: acknowledge, then idle with no pulse
    ack();
    chk("t2_qual", qual_interrupcao, 32'd0);
    chk("t2_pendente", {31'd0, pendente}, 32'd0);
    chk("t2_pc_kept", {19'd0, pc_interrup}, 32'h040);
    n0 = npulse;
    repeat (10) tick();
    chk("t2_idle_no_pulse", npulse, n0);
    ack();
    chk("t2_ack_idle_qual", qual_interrupcao, 32'd0);

    // 3: halt on the expiry edge wins
    load(16'd3, l);
    tick(); tick();
    halt = 1'b1; pc = 13'h07F;
    expect_pulse(1'b0, 1'b1, 32'd2, 13'h07F, l + 3);
    tick();
    halt = 1'b0;
    wait_pulse(6);
    chk("t3_qual", qual_interrupcao, 32'd2);
    chk("t3_pc", {19'd0, pc_interrup}, 32'h07F);
    ack();

    // 4: reload after 2 cycles restarts the quantum
    pc_next = 13'h123;
    load(16'd4, l);
    tick();
    set_clock = 1'b1; int_time = 16'd6;
    tick();
    set_clock = 1'b0;
    expect_pulse(1'b1, 1'b0, 32'd1, 13'h123, cyc + 6);
    wait_pulse(12);
    chk("t4_qual", qual_interrupcao, 32'd1);
    ack();

    // 5: halt and set_clock ignored while pending
    pc_next = 13'h055;
    load(16'd2, l);
    expect_pulse(1'b1, 1'b0, 32'd1, 13'h055, l + 2);
    wait_pulse(8);
    n0 = npulse;
    halt = 1'b1; set_clock = 1'b1; int_time = 16'd3;
    repeat (5) tick();
    halt = 1'b0; set_clock = 1'b0;
    repeat (4) tick();
    chk("t5_no_pulse", npulse, n0);
    chk("t5_qual", qual_interrupcao, 32'd1);
    chk("t5_pendente", {31'd0, pendente}, 32'd1);
    chk("t5_pc", {19'd0, pc_interrup}, 32'h055);
    ack();
`ifdef CONTADOR_INTERRUPCOES_EN
    chk("t6_total_before", {16'd0, total_interrupcoes}, nexp);
`else
    chk("t6_total_tied", {16'd0, total_interrupcoes}, 32'd0);
`endif

    // 6: asynchronous reset mid-count (counter == 2)
    load(16'd3, l);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_int_clk", {31'd0, int_clk}, 32'd0);
    chk("t6_int_halt", {31'd0, int_halt}, 32'd0);
    chk("t6_qual", qual_interrupcao, 32'd0);
    chk("t6_pc", {19'd0, pc_interrup}, 32'd0);
    chk("t6_pendente", {31'd0, pendente}, 32'd0);
    chk("t6_total", {16'd0, total_interrupcoes}, 32'd0);
    tick();
    reset_n = 1'b1;
    n0 = npulse;
    repeat (6) tick();
    chk("t6_no_pulse_after", npulse, n0);
    chk("t6_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
